// File: rtl/memory_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds RAM handshake states, arbiter FSM states and the data word type.
// No logic here; imported by memory_arbiter and starve_counter.
package memory_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // Width of the starvation counter.
  localparam int CNT_W = 3;

endpackage

// File: rtl/starve_counter.sv
// Counts data completions that happen while an instruction fetch is waiting.
// Latency: count updates on the clock edge after the qualifying event.
// Backpressure: none; saturates at all-ones and clears on instruction grant.
module starve_counter
  import memory_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_done,
  input  logic             i_pending,
  input  logic             i_enter,
  output logic [CNT_W-1:0] count
);

  // Increment on data completion with a pending fetch; clear when the fetch wins
  // or when a data completion finds no fetch waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (i_enter) begin
      count <= '0;
    end else if (d_done) begin
      if (!i_pending) begin
        count <= '0;
      end else if (count != '1) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data requests onto one single-port RAM (data first).
// Latency: grant the cycle after the request; done when RAM reports ACCESS.
// Backpressure: iwait/dwait stay high until completion; optional STARVE_GUARD_EN
// macro lets a waiting fetch win after STARVE_LIMIT back-to-back data grants.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t state, state_nxt;
  word_t      addr_q, store_q;
  logic       dreq;
  logic       force_i;

  assign dreq = dREN | dWEN;

`ifdef STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt;

  starve_counter u_starve_counter (
    .clk       (CLK),
    .rst_n     (nRST),
    .d_done    ((state == DGRANT) && (ramstate == ACCESS) && dreq),
    .i_pending (iREN),
    .i_enter   ((state == IDLE) && (state_nxt == IGRANT)),
    .count     (starve_cnt)
  );

  assign force_i = (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
  assign force_i = 1'b0;
`endif

  assign iload = ramload;
  assign dload = ramload;
  assign iwait = iREN & ~((state == IGRANT) && (ramstate == ACCESS));
  assign dwait = dreq & ~((state == DGRANT) && (ramstate == ACCESS));

  // State register; reset abandons any in-flight access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Remember the last address/store value driven so IDLE can hold them.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      addr_q  <= ramaddr;
      store_q <= ramstore;
    end
  end

  // Next-state and RAM request decode; enables follow the live request.
  always_comb begin
    state_nxt = state;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = addr_q;
    ramstore  = store_q;
    case (state)
      IDLE: begin
        if (iREN && force_i) state_nxt = IGRANT;
        else if (dreq)       state_nxt = DGRANT;
        else if (iREN)       state_nxt = IGRANT;
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN || ramstate == ACCESS || ramstate == ERROR) state_nxt = IDLE;
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq || ramstate == ACCESS || ramstate == ERROR) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
